// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline freeze/bubble/flush sequencer for a 5-stage core.
// Optional stall/flush statistics are built when PIPE_HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        if_waitreq,
   input  logic        dm_busy,
   input  logic        branch_taken,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   output logic        pc_en,
   output logic        fetch_rd,
   output logic        ifid_en,
   output logic        ifid_clr,
   output logic        idex_en,
   output logic        idex_clr,
   output logic        exmem_en,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);
   typedef enum logic [2:0] {BOOT, RUN, IWAIT, DWAIT, FLUSH} state_t;
   state_t     state_q, state_d, eff;
   logic [1:0] fcnt_q, fcnt_d;
   logic       ret_q, ret_d;
   logic       load_use;

   assign load_use = ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

   // a wait state whose condition has cleared behaves as the state it returns to
   always_comb begin
      eff = state_q;
      if (state_q == DWAIT && !dm_busy) eff = ret_q ? FLUSH : RUN;
      if (state_q == IWAIT && !if_waitreq) eff = RUN;
      {pc_en, fetch_rd, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en} = 7'b1110101;
      state_d = eff;
      fcnt_d  = fcnt_q;
      ret_d   = ret_q;
      case (eff)
         BOOT: begin
            {pc_en, fetch_rd, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en} = 7'b0001010;
            state_d = RUN;
         end
         IWAIT, DWAIT: {pc_en, fetch_rd, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en} = 7'b0100000;
         RUN: begin
            if (dm_busy) begin
               {pc_en, fetch_rd, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en} = 7'b0100000;
               state_d = DWAIT;
               ret_d   = 1'b0;
            end else if (branch_taken) begin
               ifid_clr = 1'b1;
               idex_clr = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  fcnt_d  = 2'(FLUSH_CYCLES - 2);
                  state_d = FLUSH;
               end
            end else if (if_waitreq) begin
               {pc_en, fetch_rd, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en} = 7'b0100000;
               state_d = IWAIT;
            end else if (load_use) begin
               pc_en    = 1'b0;
               ifid_en  = 1'b0;
               idex_clr = 1'b1;
            end
         end
         FLUSH: begin
            if (dm_busy) begin
               {pc_en, fetch_rd, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en} = 7'b0100000;
               state_d = DWAIT;
               ret_d   = 1'b1;
            end else begin
               ifid_clr = 1'b1;
               if (fcnt_q == 2'd0) begin
                  state_d = RUN;
                  ret_d   = 1'b0;
               end else begin
                  fcnt_d = fcnt_q - 2'd1;
               end
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= BOOT;
         fcnt_q  <= 2'd0;
         ret_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         ret_q   <= ret_d;
      end
   end

`ifdef PIPE_HAZARD_STATS_EN
   logic [15:0] stall_q, flush_q;
   // a redirect is the only case with pc_en and idex_clr both high
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         if (state_q != BOOT && !pc_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
         if (pc_en && idex_clr && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
      end
   end
   assign stall_count = stall_q;
   assign flush_count = flush_q;
`else
   assign stall_count = 16'd0;
   assign flush_count = 16'd0;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, number of IF/ID flush cycles per taken branch (legal 1..3).
REQ-002 SHALL have ports:
- CLK, in, 1, single clock, rising edge.
- RST_n, in, 1, asynchronous active-low reset.
- if_waitreq, in, 1, instruction-bus waitrequest.
- dm_busy, in, 1, data-memory waitrequest seen by the MEM stage.
- branch_taken, in, 1, EX-stage taken branch or jump.
- ex_memread, in, 1, EX-stage instruction is a load.
- ex_rd, in, 5, EX-stage destination register.
- id_rs1, in, 5, ID-stage source register 1.
- id_rs2, in, 5, ID-stage source register 2.
- pc_en, out, 1, PC register load enable.
- fetch_rd, out, 1, instruction-bus read request.
- ifid_en, out, 1, IF/ID register enable.
- ifid_clr, out, 1, IF/ID register clear.
- idex_en, out, 1, ID/EX register enable.
- idex_clr, out, 1, ID/EX register clear (bubble).
- exmem_en, out, 1, EX/MEM and MEM/WB register enable.
- stall_count, out, 16, stall-cycle counter.
- flush_count, out, 16, taken-branch counter.

Function
REQ-003 SHALL implement an FSM with states BOOT, RUN, IWAIT, DWAIT and FLUSH, plus a 2-bit flush counter fcnt.
REQ-004 SHALL drive all outputs combinationally from state and inputs; "default" means pc_en=1, fetch_rd=1, ifid_en=1, idex_en=1, exmem_en=1, ifid_clr=0, idex_clr=0.
REQ-005 SHALL hold BOOT for exactly one cycle after reset release: fetch_rd=0, pc_en=0, ifid_clr=1, idex_clr=1, all enables 0; next state RUN.
REQ-006 SHALL evaluate RUN by fixed priority: dm_busy, then branch_taken, then if_waitreq, then load-use; with none active, outputs are default.
REQ-007 SHALL, on dm_busy in RUN, drive pc_en=ifid_en=idex_en=exmem_en=0 with fetch_rd=1 and go to DWAIT.
REQ-008 SHALL stay in DWAIT with all enables 0 while dm_busy=1; with dm_busy=0 it SHALL produce RUN outputs that same cycle and take the RUN next state.
REQ-009 SHALL, on branch_taken in RUN, drive pc_en=1, ifid_clr=1 and idex_clr=1; if FLUSH_CYCLES>1 it SHALL load fcnt=FLUSH_CYCLES-2 and go to FLUSH.
REQ-010 SHALL, in FLUSH, drive default outputs with ifid_clr=1; it SHALL decrement fcnt each cycle and return to RUN after the cycle with fcnt=0, unless dm_busy (REQ-007 behaviour, and FLUSH resumes after DWAIT).
REQ-011 SHALL, on if_waitreq in RUN, drive pc_en=ifid_en=idex_en=exmem_en=0 with fetch_rd=1 held and go to IWAIT.
REQ-012 SHALL, in IWAIT with if_waitreq=1, keep the whole pipeline frozen and fetch_rd=1; with if_waitreq=0 it SHALL produce RUN outputs that same cycle and take the RUN next state.
REQ-013 SHALL detect load-use as ex_memread=1, ex_rd!=0, and ex_rd equal to id_rs1 or id_rs2.
REQ-014 SHALL, on load-use, drive pc_en=0, ifid_en=0, idex_clr=1 and exmem_en=1 for exactly one cycle and stay in RUN.
REQ-015 SHALL never assert ifid_clr and ifid_en=0 together with pc_en=1 outside a branch redirect.
REQ-016 SHALL, when branch_taken and if_waitreq coincide, act on the branch (priority, REQ-006) while keeping fetch_rd=1 until the bus accepts the request.

Reset
REQ-017 SHALL, while RST_n=0, force state=BOOT, fcnt=0, counters=0, pc_en=0, fetch_rd=0, ifid_clr=1, idex_clr=1 and all enables 0, independent of CLK.
REQ-018 SHALL, on reset asserted mid-FLUSH, IWAIT or DWAIT, abandon the operation with no pending state retained.

Configuration
REQ-019 SHALL, with macro PIPE_HAZARD_STATS_EN defined, increment stall_count (saturating at 16'hFFFF) each cycle pc_en=0 outside BOOT, and flush_count (saturating) each branch redirect.
REQ-020 SHALL, without PIPE_HAZARD_STATS_EN, tie stall_count and flush_count to 16'd0 with no counter flops.

Verification
REQ-021 SHALL cover reset release: check one BOOT cycle with fetch_rd=0 and ifid_clr=1, then default outputs.
REQ-022 SHALL cover load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_clr=1; ex_rd=0 -> no stall.
REQ-023 SHALL cover branch with FLUSH_CYCLES=3: branch_taken for 1 cycle -> ifid_clr=1 for 3 cycles, idex_clr=1 for 1 cycle, flush_count=1.
REQ-024 SHALL cover if_waitreq held 4 cycles -> pipeline frozen 4 cycles, fetch_rd=1 throughout, stall_count=4 with the macro defined.
REQ-025 SHALL cover dm_busy and branch_taken in the same cycle -> freeze first, branch redirect in the cycle dm_busy drops.
REQ-026 SHALL cover RST_n pulsed low mid-FLUSH -> immediate BOOT outputs, and the counters read 0.
